// File: rtl/bcd_sub_arb.sv
// Round-robin arbiter and sequencer for one shared three-digit BCD subtractor.
// Validates operands, holds them for SETTLE cycles, then captures |a-b| and sign.
module bcd_sub_arb #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [11:0] a0,
  input  logic [11:0] b0,
  input  logic        req1,
  input  logic [11:0] a1,
  input  logic [11:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [11:0] result,
  output logic        negative,
  output logic        err,
  output logic        src,
  output logic [11:0] sub_a,
  output logic [11:0] sub_b,
  input  logic [11:0] sub_out,
  input  logic        sub_neg
);

  typedef enum logic [1:0] {StIdle, StLoad, StSettle, StDone} state_e;

  localparam logic [3:0] CntLast = 4'(SETTLE - 1);

  state_e      state_q, state_d;
  logic        sel_q, sel_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] sub_a_q, sub_a_d;
  logic [11:0] sub_b_q, sub_b_d;
  logic [11:0] result_q, result_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        src_q, src_d;

  logic [11:0] op_a, op_b;
  logic        op_bad;

  function automatic logic has_bad_digit(input logic [11:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  assign op_a   = sel_q ? a1 : a0;
  assign op_b   = sel_q ? b1 : b0;
  assign op_bad = has_bad_digit(op_a) | has_bad_digit(op_b);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    sub_a_d  = sub_a_q;
    sub_b_d  = sub_b_q;
    result_d = result_q;
    neg_d    = neg_q;
    err_d    = err_q;
    src_d    = src_q;
    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          sel_d   = (req0 && req1) ? ~last_q : req1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (op_bad) begin
          // Bad digits never reach the subtractor; report the error directly.
          err_d    = 1'b1;
          result_d = 12'h000;
          neg_d    = 1'b0;
          src_d    = sel_q;
          last_d   = sel_q;
          state_d  = StDone;
        end else begin
          sub_a_d = op_a;
          sub_b_d = op_b;
          cnt_d   = 4'd0;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == CntLast) begin
          result_d = sub_out;
          neg_d    = sub_neg;
          err_d    = 1'b0;
          src_d    = sel_q;
          last_d   = sel_q;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sel_q    <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= 4'd0;
      sub_a_q  <= 12'h000;
      sub_b_q  <= 12'h000;
      result_q <= 12'h000;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      src_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      sub_a_q  <= sub_a_d;
      sub_b_q  <= sub_b_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      src_q    <= src_d;
    end
  end

  always_comb begin
    gnt0  = (state_q != StIdle) && !sel_q;
    gnt1  = (state_q != StIdle) && sel_q;
    done0 = (state_q == StDone) && !sel_q;
    done1 = (state_q == StDone) && sel_q;
  end

  assign result   = result_q;
  assign negative = neg_q;
  assign err      = err_q;
  assign src      = src_q;
  assign sub_a    = sub_a_q;
  assign sub_b    = sub_b_q;

endmodule

// File: tb/tb_bcd_sub_arb.sv
// Scoreboard bench for bcd_sub_arb: two requester processes push expected jobs,
// a negedge monitor pops and checks on every done pulse against a decimal model.
module tb_bcd_sub_arb;

  localparam int unsigned SETTLE = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [11:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [11:0] result;
  logic        negative, err, src;
  logic [11:0] sub_a, sub_b;
  logic [11:0] sub_out;
  logic        sub_neg;

  always #5 clk = ~clk;

  bcd_sub_arb #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .negative(negative), .err(err), .src(src),
    .sub_a(sub_a), .sub_b(sub_b), .sub_out(sub_out), .sub_neg(sub_neg)
  );

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] res;
    logic        neg;
    logic        err;
  } job_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  job_t        exp_q0[$];
  job_t        exp_q1[$];
  int          grant_log[$];

  function automatic int bcd2int(input logic [11:0] v);
    return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int n);
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic bad_bcd(input logic [11:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic job_t ref_job(input logic [11:0] a, input logic [11:0] b);
    job_t j;
    int   d;
    j.a = a;
    j.b = b;
    if (bad_bcd(a) || bad_bcd(b)) begin
      j.err = 1'b1; j.res = 12'h000; j.neg = 1'b0;
    end else begin
      d     = bcd2int(a) - bcd2int(b);
      j.err = 1'b0;
      j.neg = (d < 0);
      j.res = int2bcd(d < 0 ? -d : d);
    end
    return j;
  endfunction

  // External subtractor model: result appears two cycles after operands change.
  logic [11:0] sm1, sm2;
  logic        sn1, sn2;
  always @(posedge clk) begin
    int d;
    d = bcd2int(sub_a) - bcd2int(sub_b);
    sn1 <= (d < 0);
    sm1 <= int2bcd(d < 0 ? -d : d);
    sn2 <= sn1;
    sm2 <= sm1;
  end
  assign sub_out = sm2;
  assign sub_neg = sn2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_gnt0", gnt0, 0);     check("rst_gnt1", gnt1, 0);
    check("rst_done0", done0, 0);   check("rst_done1", done1, 0);
    check("rst_result", result, 0); check("rst_negative", negative, 0);
    check("rst_err", err, 0);       check("rst_src", src, 0);
    check("rst_sub_a", sub_a, 0);   check("rst_sub_b", sub_b, 0);
  endtask

  // Raise a request, hold it until done (optionally dropping it once granted),
  // then drop it on the edge that samples done. Cycle 0 is the first IDLE sample.
  task automatic issue(input bit idx, input logic [11:0] a, input logic [11:0] b,
                       input bit early, output int load_at, output int done_at);
    job_t j;
    int   n;
    bit   got;
    j = ref_job(a, b);
    @(posedge clk); #1;
    if (idx) begin a1 = a; b1 = b; req1 = 1'b1; exp_q1.push_back(j); end
    else     begin a0 = a; b0 = b; req0 = 1'b1; exp_q0.push_back(j); end
    n = 0; got = 1'b0; load_at = -1; done_at = -1;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if ((idx ? gnt1 : gnt0) && load_at < 0) begin
        load_at = n - 1;
        if (early) begin
          if (idx) req1 = 1'b0; else req0 = 1'b0;
        end
      end
      if (idx ? done1 : done0) begin got = 1'b1; done_at = n - 1; end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL done_timeout: requester %0d got no done, expected one", idx);
    end
    @(posedge clk); #1;
    if (idx) req1 = 1'b0; else req0 = 1'b0;
  endtask

  // Monitor: arbitration model, scoreboard pop and checks on done.
  bit          r0_s, r1_s;
  bit          m_last = 1'b1;
  bit          gnt_prev = 1'b0;
  bit          cur = 1'b0;
  int          load_cyc = 0;
  logic [11:0] m_sub_a = 12'h000, m_sub_b = 12'h000;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    r0_s <= req0;
    r1_s <= req1;
  end

  always @(negedge clk) begin
    job_t jm;
    bit   w, expw;
    if (rst) begin
      exp_q0.delete(); exp_q1.delete();
      m_last = 1'b1; gnt_prev = 1'b0; m_sub_a = 12'h000; m_sub_b = 12'h000;
    end else begin
      check("gnt_exclusive", gnt0 && gnt1, 0);
      check("done_exclusive", done0 && done1, 0);
      if ((gnt0 || gnt1) && !gnt_prev) begin
        expw = (r0_s && r1_s) ? !m_last : r1_s;
        check("arb_winner", gnt1, expw);
        cur      = gnt1;
        load_cyc = cyc;
        grant_log.push_back(int'(gnt1));
      end
      gnt_prev = gnt0 || gnt1;
      if (done0 || done1) begin
        w = done1;
        check("done_owner", w, cur);
        check("gnt_at_done", w ? gnt1 : gnt0, 1);
        if ((w ? exp_q1.size() : exp_q0.size()) == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: done%0d with no job pending, expected none", w);
        end else begin
          jm = w ? exp_q1.pop_front() : exp_q0.pop_front();
          if (!jm.err) begin m_sub_a = jm.a; m_sub_b = jm.b; end
          check("result", result, jm.res);
          check("negative", negative, jm.neg);
          check("err", err, jm.err);
          check("src", src, w);
          check("latency", cyc - load_cyc, jm.err ? 1 : 1 + SETTLE);
          check("sub_a", sub_a, m_sub_a);
          check("sub_b", sub_b, m_sub_b);
        end
        m_last = w;
      end
    end
  end

  function automatic logic [11:0] rand_bcd();
    logic [11:0] v;
    for (int i = 0; i < 3; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 9) == 0) v[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  initial begin
    int la, da, lb, db;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1 rst = 1'b0;

    // Directed jobs, each uncontended.
    issue(0, 12'h123, 12'h045, 0, la, da);
    check("basic_load_cycle", la, 1);
    check("basic_done_cycle", da, 2 + SETTLE);
    issue(1, 12'h045, 12'h123, 0, la, da);
    check("neg_done_cycle", da, 2 + SETTLE);
    issue(0, 12'h000, 12'h000, 0, la, da);
    issue(0, 12'h1A3, 12'h045, 0, la, da);
    check("bad_done_cycle", da, 2);
    issue(1, 12'h999, 12'h000, 0, la, da);
    issue(1, 12'h000, 12'h999, 0, la, da);
    issue(0, 12'h200, 12'h10F, 0, la, da);

    // Tie from reset: requester 0 first, then strict alternation.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    grant_log.delete();
    fork
      begin issue(0, 12'h500, 12'h250, 0, la, da); issue(0, 12'h010, 12'h001, 0, la, da); end
      begin issue(1, 12'h333, 12'h444, 0, lb, db); issue(1, 12'h876, 12'h123, 0, lb, db); end
    join
    check("tie_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("tie_grant_order", grant_log[i], i % 2);

    // Reset during SETTLE discards the job.
    @(posedge clk); #1 a0 = 12'h500; b0 = 12'h001; req0 = 1'b1;
    for (int k = 0; k < 20 && !gnt0; k++) @(negedge clk);
    check("midjob_gnt", gnt0, 1);
    @(posedge clk); #1 rst = 1'b1; req0 = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    for (int k = 0; k < SETTLE + 4; k++) begin
      @(negedge clk);
      check("no_done_after_rst", done0 || done1, 0);
    end
    issue(0, 12'h500, 12'h001, 0, la, da);
    check("reissue_load_cycle", la, 1);
    check("reissue_done_cycle", da, 2 + SETTLE);

    // Randomized contention with occasional early request drops.
    fork
      begin
        int l0, d0;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          issue(0, rand_bcd(), rand_bcd(), $urandom_range(0, 4) == 0, l0, d0);
        end
      end
      begin
        int l1, d1;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          issue(1, rand_bcd(), rand_bcd(), $urandom_range(0, 4) == 0, l1, d1);
        end
      end
    join

    repeat (5) @(negedge clk);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
